// File: rtl/coeff_pkg.sv
// coeff_stream shared types and default coefficient set.
// Optional table write port is enabled with COEFF_WR_EN.
package coeff_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int NDEF      = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic signed [15:0] DEF_TAB [NDEF] = '{
        -16'sd1024, -16'sd170, -16'sd68, -16'sd36,
        -16'sd23,   -16'sd16,  -16'sd11, 16'sd0
    };

    // Entries beyond the known series (or beyond depth) read as zero.
    function automatic logic signed [31:0] def_coeff(
        input int depth,
        input int idx
    );
        if (idx < 0 || idx >= depth || idx >= NDEF)
            return 32'sd0;
        return 32'(DEF_TAB[idx]);
    endfunction

endpackage

// File: rtl/coeff_table.sv
// Coefficient storage with combinational read mux.
// COEFF_WR_EN selects a writable register table; otherwise ROM.
module coeff_table
    import coeff_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH)
) (
`ifdef COEFF_WR_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
`endif
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

`ifdef COEFF_WR_EN
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= WIDTH'(def_coeff(DEPTH, i));
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
`else
    always_comb begin
        rd_data = WIDTH'(def_coeff(DEPTH, int'(rd_addr)));
    end
`endif

endmodule

// File: rtl/coeff_stream.sv
// Coefficient table with a valid/ready run sequencer.
// COEFF_WR_EN adds the wr_en/wr_addr/wr_data table write port.
module coeff_stream
    import coeff_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W:0]   count,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
`ifdef COEFF_WR_EN
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic             done
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [IDX_W:0]   rem, rem_n;
    logic [IDX_W-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             hs;

    coeff_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
`ifdef COEFF_WR_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign out_valid = (state == RUN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_last  = out_valid && (rem == ONE);
    assign out_data  = data_q;
    assign out_idx   = idx;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data_q;
        rem_n   = rem;
        rd_addr = idx + IDX_W'(1);
        unique case (state)
            IDLE: begin
                rd_addr = first_idx;
                if (start) begin
                    if (count == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        idx_n   = first_idx;
                        data_n  = rd_data;
                        rem_n   = (count > FULL) ? FULL : count;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    if (rem == ONE) begin
                        state_n = DONE;
                    end else begin
                        idx_n  = idx + IDX_W'(1);
                        data_n = rd_data;
                        rem_n  = rem - ONE;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            data_q <= '0;
            rem    <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            data_q <= data_n;
            rem    <= rem_n;
        end
    end

endmodule

// File: tb/tb_coeff_stream.sv
// Directed bench for coeff_stream; write-port steps run
// only when COEFF_WR_EN is defined.
module tb_coeff_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W:0]   count;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             done;
`ifdef COEFF_WR_EN
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
`endif

    int ntests = 0;
    int nfail  = 0;
    int beats;
    logic seen_done;

    logic signed [15:0] exp_tab [8] = '{
        -16'sd1024, -16'sd170, -16'sd68, -16'sd36,
        -16'sd23,   -16'sd16,  -16'sd11, 16'sd0
    };

    always #5 clk = ~clk;

    coeff_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_idx (first_idx),
        .count     (count),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef COEFF_WR_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .done      (done)
    );

    task automatic chk(
        input string       tag,
        input logic [15:0] obs,
        input logic [15:0] exp
    );
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic beat(
        input string       tag,
        input logic [15:0] d,
        input logic [15:0] i,
        input logic [15:0] l
    );
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_idx"},   16'(out_idx), i);
        chk({tag, "_last"},  16'(out_last), l);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(
        input logic [IDX_W-1:0] fi,
        input logic [IDX_W:0]   cnt
    );
        start     = 1'b1;
        first_idx = fi;
        count     = cnt;
        step();
        start     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        first_idx = '0;
        count     = '0;
        out_ready = 1'b1;
`ifdef COEFF_WR_EN
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
`endif
        step();
        step();
        chk("rst_busy",  16'(busy), 16'd0);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_done",  16'(done), 16'd0);
        chk("rst_last",  16'(out_last), 16'd0);
        chk("rst_data",  out_data, 16'd0);
        chk("rst_idx",   16'(out_idx), 16'd0);
        rst_n = 1'b1;
        step();

        // full run from index 0
        kick(3'd0, 4'd8);
        for (int k = 0; k < 8; k++) begin
            beat($sformatf("full%0d", k), exp_tab[k],
                 16'(k), 16'(k == 7));
            chk("full_busy", 16'(busy), 16'd1);
            step();
        end
        chk("full_done",  16'(done), 16'd1);
        chk("full_dvld",  16'(out_valid), 16'd0);
        chk("full_dlast", 16'(out_last), 16'd0);
        step();
        chk("full_done0", 16'(done), 16'd0);
        chk("full_idle",  16'(busy), 16'd0);

        // wrap around the end of the table
        kick(3'd6, 4'd4);
        beat("wrap0", exp_tab[6], 16'd6, 16'd0);
        step();
        beat("wrap1", exp_tab[7], 16'd7, 16'd0);
        step();
        beat("wrap2", exp_tab[0], 16'd0, 16'd0);
        step();
        beat("wrap3", exp_tab[1], 16'd1, 16'd1);
        step();
        chk("wrap_done", 16'(done), 16'd1);
        step();

        // backpressure 1,0,0,1 plus a stall on the last beat
        kick(3'd0, 4'd3);
        beat("stA", exp_tab[0], 16'd0, 16'd0);
        step();
        out_ready = 1'b0;
        start     = 1'b1;
        first_idx = 3'd5;
        beat("stB", exp_tab[1], 16'd1, 16'd0);
        step();
        start = 1'b0;
        beat("stC", exp_tab[1], 16'd1, 16'd0);
        step();
        out_ready = 1'b1;
        beat("stD", exp_tab[1], 16'd1, 16'd0);
        step();
        out_ready = 1'b0;
        beat("stE", exp_tab[2], 16'd2, 16'd1);
        step();
        beat("stF", exp_tab[2], 16'd2, 16'd1);
        out_ready = 1'b1;
        step();
        chk("st_done", 16'(done), 16'd1);
        chk("st_dvld", 16'(out_valid), 16'd0);
        step();
        chk("st_idle", 16'(busy), 16'd0);

        // empty run
        kick(3'd3, 4'd0);
        chk("c0_done",  16'(done), 16'd1);
        chk("c0_valid", 16'(out_valid), 16'd0);
        chk("c0_busy",  16'(busy), 16'd1);
        step();
        chk("c0_done0", 16'(done), 16'd0);
        chk("c0_idle",  16'(busy), 16'd0);

        // oversize count saturates to DEPTH
        kick(3'd0, 4'd12);
        beats     = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (out_valid && out_ready) beats++;
            if (done) seen_done = 1'b1;
            step();
        end
        chk("c12_beats", 16'(beats), 16'd8);
        chk("c12_done",  16'(seen_done), 16'd1);

        // reset while beat 3 is presented
        kick(3'd0, 4'd8);
        step();
        step();
        beat("mr_b3", exp_tab[2], 16'd2, 16'd0);
        rst_n = 1'b0;
        step();
        chk("mr_busy",  16'(busy), 16'd0);
        chk("mr_valid", 16'(out_valid), 16'd0);
        chk("mr_done",  16'(done), 16'd0);
        chk("mr_last",  16'(out_last), 16'd0);
        chk("mr_data",  out_data, 16'd0);
        chk("mr_idx",   16'(out_idx), 16'd0);
        rst_n = 1'b1;
        step();
        chk("mr_done1", 16'(done), 16'd0);
        chk("mr_busy1", 16'(busy), 16'd0);

`ifdef COEFF_WR_EN
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 16'h0123;
        step();
        wr_en = 1'b0;
        kick(3'd2, 4'd1);
        beat("wr_new", 16'h0123, 16'd2, 16'd1);
        step();
        chk("wr_done", 16'(done), 16'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        kick(3'd2, 4'd1);
        beat("wr_rst", exp_tab[2], 16'd2, 16'd1);
        step();
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
